// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//    Lets two requesters share one purely combinational ALU, which is
//    instantiated outside this block. A round-robin arbiter picks one request,
//    registers its operands and control code onto the ALU inputs, captures
//    the ALU result one cycle later, and returns it over a valid/ready
//    response handshake. Only one operation is in flight at a time:
//    IDLE -> EXEC -> RESP -> IDLE.
//
// Optional feature (macro ALU_CTRL_CHECK_EN):
//    When defined, an unsupported control code is still accepted. The ALU is
//    forced to PassB with BusB=0, and the response reports rsp_err_o=1.
//    When undefined, the control code goes to the ALU unchanged and
//    rsp_err_o stays 0.
//
// Ports:
//    clk_i          clock; all state updates on posedge
//    resetl_i       synchronous reset, active low
//    req_valid_i    [1:0] per-requester operation request
//    req_ready_o    [1:0] per-requester accept (combinational, IDLE only)
//    req_a_i        [2*WIDTH-1:0] operand A, requester i at [i*WIDTH +: WIDTH]
//    req_b_i        [2*WIDTH-1:0] operand B, same packing
//    req_ctrl_i     [2*CTRL_W-1:0] ALU control code, same packing
//    rsp_valid_o    [1:0] result valid for the granted requester
//    rsp_ready_i    [1:0] requester i takes the result
//    rsp_result_o   [WIDTH-1:0] captured ALU result
//    rsp_zero_o     captured ALU Zero flag
//    rsp_err_o      illegal control code flag
//    alu_busa_o     [WIDTH-1:0] to ALU BusA (registered)
//    alu_busb_o     [WIDTH-1:0] to ALU BusB (registered)
//    alu_ctrl_o     [CTRL_W-1:0] to ALU ALUCtrl (registered)
//    alu_busw_i     [WIDTH-1:0] from ALU BusW
//    alu_zero_i     from ALU Zero
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int WIDTH  = 64,
   parameter int CTRL_W = 4
) (
   input  logic                  clk_i,
   input  logic                  resetl_i,
   input  logic [1:0]            req_valid_i,
   output logic [1:0]            req_ready_o,
   input  logic [2*WIDTH-1:0]    req_a_i,
   input  logic [2*WIDTH-1:0]    req_b_i,
   input  logic [2*CTRL_W-1:0]   req_ctrl_i,
   output logic [1:0]            rsp_valid_o,
   input  logic [1:0]            rsp_ready_i,
   output logic [WIDTH-1:0]      rsp_result_o,
   output logic                  rsp_zero_o,
   output logic                  rsp_err_o,
   output logic [WIDTH-1:0]      alu_busa_o,
   output logic [WIDTH-1:0]      alu_busb_o,
   output logic [CTRL_W-1:0]     alu_ctrl_o,
   input  logic [WIDTH-1:0]      alu_busw_i,
   input  logic                  alu_zero_i
);

   localparam logic [CTRL_W-1:0] CTRL_PASSB = CTRL_W'(7);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_RESP = 2'b10
   } state_t;

`ifdef ALU_CTRL_CHECK_EN
   // Codes the ALU implements: AND, OR, ADD, SUB, PassB.
   function automatic logic ctrl_legal(input logic [CTRL_W-1:0] c);
      logic ok;
      case (c)
         CTRL_W'(0): ok = 1'b1;
         CTRL_W'(1): ok = 1'b1;
         CTRL_W'(2): ok = 1'b1;
         CTRL_W'(6): ok = 1'b1;
         CTRL_W'(7): ok = 1'b1;
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction
`endif

   state_t              state_q;
   state_t              state_d;
   logic                last_grant_q;
   logic                grant_q;
   logic [WIDTH-1:0]    alu_busa_q;
   logic [WIDTH-1:0]    alu_busb_q;
   logic [CTRL_W-1:0]   alu_ctrl_q;
   logic [WIDTH-1:0]    rsp_result_q;
   logic                rsp_zero_q;
   logic                rsp_err_q;
   logic                err_pend_q;
   logic [1:0]          rsp_valid_q;

   logic                any_valid_s;
   logic                winner_s;
   logic                xfer_s;
   logic [WIDTH-1:0]    sel_a_s;
   logic [WIDTH-1:0]    sel_b_s;
   logic [CTRL_W-1:0]   sel_ctrl_s;
   logic [WIDTH-1:0]    eff_b_s;
   logic [CTRL_W-1:0]   eff_ctrl_s;
   logic                illegal_s;

   assign any_valid_s = |req_valid_i;

   // Round-robin winner: a lone requester wins; on contention the one not served last wins.
   always_comb begin
      winner_s = 1'b0;
      case (req_valid_i)
         2'b01:   winner_s = 1'b0;
         2'b10:   winner_s = 1'b1;
         2'b11:   winner_s = ~last_grant_q;
         default: winner_s = 1'b0;
      endcase
   end

   // Accept only in IDLE and never while reset is asserted, so ready reads 0 during reset.
   always_comb begin
      req_ready_o = 2'b00;
      xfer_s      = 1'b0;
      if ((state_q == S_IDLE) && any_valid_s && resetl_i) begin
         xfer_s      = 1'b1;
         req_ready_o = winner_s ? 2'b10 : 2'b01;
      end else begin
         xfer_s      = 1'b0;
         req_ready_o = 2'b00;
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      sel_a_s    = '0;
      sel_b_s    = '0;
      sel_ctrl_s = '0;
      if (winner_s) begin
         sel_a_s    = req_a_i[WIDTH +: WIDTH];
         sel_b_s    = req_b_i[WIDTH +: WIDTH];
         sel_ctrl_s = req_ctrl_i[CTRL_W +: CTRL_W];
      end else begin
         sel_a_s    = req_a_i[0 +: WIDTH];
         sel_b_s    = req_b_i[0 +: WIDTH];
         sel_ctrl_s = req_ctrl_i[0 +: CTRL_W];
      end
   end

   // Illegal codes become PassB of zero, so the ALU returns BusW=0 and Zero=1.
   always_comb begin
      illegal_s  = 1'b0;
      eff_b_s    = sel_b_s;
      eff_ctrl_s = sel_ctrl_s;
`ifdef ALU_CTRL_CHECK_EN
      illegal_s = ~ctrl_legal(sel_ctrl_s);
      if (illegal_s) begin
         eff_b_s    = '0;
         eff_ctrl_s = CTRL_PASSB;
      end else begin
         eff_b_s    = sel_b_s;
         eff_ctrl_s = sel_ctrl_s;
      end
`endif
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (xfer_s) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: state_d = S_RESP;
         S_RESP: begin
            if (rsp_ready_i[grant_q]) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state and all registered datapath/outputs.
   always_ff @(posedge clk_i) begin
      if (!resetl_i) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         alu_busa_q   <= '0;
         alu_busb_q   <= '0;
         alu_ctrl_q   <= CTRL_PASSB;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         err_pend_q   <= 1'b0;
         rsp_valid_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (xfer_s) begin
                  alu_busa_q   <= sel_a_s;
                  alu_busb_q   <= eff_b_s;
                  alu_ctrl_q   <= eff_ctrl_s;
                  err_pend_q   <= illegal_s;
                  grant_q      <= winner_s;
                  last_grant_q <= winner_s;
               end
            end
            S_EXEC: begin
               // ALU inputs have been stable for a full cycle; sample its outputs.
               rsp_result_q <= alu_busw_i;
               rsp_zero_q   <= alu_zero_i;
               rsp_err_q    <= err_pend_q;
               rsp_valid_q  <= grant_q ? 2'b10 : 2'b01;
            end
            S_RESP: begin
               if (rsp_ready_i[grant_q]) begin
                  rsp_valid_q <= 2'b00;
               end
            end
            default: rsp_valid_q <= 2'b00;
         endcase
      end
   end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_zero_o   = rsp_zero_q;
   assign rsp_err_o    = rsp_err_q;
   assign alu_busa_o   = alu_busa_q;
   assign alu_busb_o   = alu_busb_q;
   assign alu_ctrl_o   = alu_ctrl_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed bench for alu_share_arbiter. A behavioural 64-bit ALU
// (AND/OR/ADD/SUB/PassB) closes the loop on the alu_* ports. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

   localparam logic [3:0] C_AND  = 4'b0000;
   localparam logic [3:0] C_OR   = 4'b0001;
   localparam logic [3:0] C_ADD  = 4'b0010;
   localparam logic [3:0] C_SUB  = 4'b0110;
   localparam logic [3:0] C_PASS = 4'b0111;

   logic          clk;
   logic          resetl;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [127:0]  req_a;
   logic [127:0]  req_b;
   logic [7:0]    req_ctrl;
   logic [1:0]    rsp_valid;
   logic [1:0]    rsp_ready;
   logic [63:0]   rsp_result;
   logic          rsp_zero;
   logic          rsp_err;
   logic [63:0]   alu_busa;
   logic [63:0]   alu_busb;
   logic [3:0]    alu_ctrl;
   logic [63:0]   alu_busw;
   logic          alu_zero;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.WIDTH(64), .CTRL_W(4)) dut (
      .clk_i        (clk),
      .resetl_i     (resetl),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .req_ctrl_i   (req_ctrl),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_result_o (rsp_result),
      .rsp_zero_o   (rsp_zero),
      .rsp_err_o    (rsp_err),
      .alu_busa_o   (alu_busa),
      .alu_busb_o   (alu_busb),
      .alu_ctrl_o   (alu_ctrl),
      .alu_busw_i   (alu_busw),
      .alu_zero_i   (alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU outside the arbiter.
   always_comb begin
      alu_busw = 64'hDEAD_BEEF_DEAD_BEEF;
      case (alu_ctrl)
         C_AND:   alu_busw = alu_busa & alu_busb;
         C_OR:    alu_busw = alu_busa | alu_busb;
         C_ADD:   alu_busw = alu_busa + alu_busb;
         C_SUB:   alu_busw = alu_busa - alu_busb;
         C_PASS:  alu_busw = alu_busb;
         default: alu_busw = 64'hDEAD_BEEF_DEAD_BEEF;
      endcase
      alu_zero = (alu_busw == 64'd0);
   end

   task automatic set_req(input int r, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] c);
      req_a[r*64 +: 64]  = a;
      req_b[r*64 +: 64]  = b;
      req_ctrl[r*4 +: 4] = c;
      req_valid[r]       = 1'b1;
   endtask

   // Counts falling edges until rsp_valid rises; gives up after 10.
   task automatic wait_rsp(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rsp_valid == 2'b00 && n < 10);
   endtask

   // Waits (bounded) for an IDLE cycle in which some request is offered ready.
   task automatic wait_ready(output int n);
      n = 0;
      while (req_ready == 2'b00 && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset;
      resetl = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || alu_busa !== 64'd0 ||
          alu_busb !== 64'd0 || alu_ctrl !== 4'b0111 || rsp_result !== 64'd0 ||
          rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset: rv=%b rr=%b a=%h b=%h c=%b res=%h z=%b e=%b, expected all zero, ctrl 0111",
                  rsp_valid, req_ready, alu_busa, alu_busb, alu_ctrl, rsp_result, rsp_zero, rsp_err);
      end
      resetl = 1'b1;
   endtask

   task automatic test_add;
      int n;
      @(negedge clk);
      set_req(0, 64'd5, 64'd7, C_ADD);
      rsp_ready = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL add_ready: got %b expected 01", req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      set_req(0, 64'd99, 64'd99, C_SUB);
      req_valid = 2'b00;
      wait_rsp(n);
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL add_latency: got %0d edges expected 2", n);
      end
      checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== 64'd12 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL add_rsp: rv=%b res=%0d z=%b e=%b expected 01 12 0 0",
                  rsp_valid, rsp_result, rsp_zero, rsp_err);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL add_done: rsp_valid=%b expected 00", rsp_valid);
      end
   endtask

   task automatic test_sub;
      int n;
      rsp_ready = 2'b10;
      set_req(1, 64'd9, 64'd9, C_SUB);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      wait_rsp(n);
      checks++;
      if (rsp_valid !== 2'b10 || rsp_result !== 64'd0 || rsp_zero !== 1'b1) begin
         errors++;
         $display("FAIL sub_eq: rv=%b res=%h z=%b expected 10 0 1", rsp_valid, rsp_result, rsp_zero);
      end
      @(negedge clk);
      set_req(1, 64'd0, 64'd1, C_SUB);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      wait_rsp(n);
      checks++;
      if (rsp_valid !== 2'b10 || rsp_result !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_zero !== 1'b0) begin
         errors++;
         $display("FAIL sub_wrap: rv=%b res=%h z=%b expected 10 ffffffffffffffff 0",
                  rsp_valid, rsp_result, rsp_zero);
      end
      @(negedge clk);
   endtask

   task automatic test_round_robin;
      logic [1:0]  exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      logic [63:0] exp_res [4] = '{64'hF000, 64'hFF, 64'h1234, 64'h0};
      logic        exp_z   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int n;
      rsp_ready = 2'b11;
      set_req(0, 64'hF0F0, 64'hFF00, C_AND);
      set_req(1, 64'hF0, 64'h0F, C_OR);
      #1;
      for (int k = 0; k < 4; k++) begin
         wait_ready(n);
         checks++;
         if (req_ready !== exp_rdy[k]) begin
            errors++;
            $display("FAIL rr_grant%0d: req_ready=%b expected %b", k, req_ready, exp_rdy[k]);
         end
         @(posedge clk);
         #1;
         if (k == 0) set_req(0, 64'd1, 64'h1234, C_PASS);
         if (k == 1) set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, C_ADD);
         if (k == 3) req_valid = 2'b00;
         wait_rsp(n);
         checks++;
         if (rsp_valid !== exp_rdy[k] || rsp_result !== exp_res[k] || rsp_zero !== exp_z[k]) begin
            errors++;
            $display("FAIL rr_rsp%0d: rv=%b res=%h z=%b expected %b %h %b",
                     k, rsp_valid, rsp_result, rsp_zero, exp_rdy[k], exp_res[k], exp_z[k]);
         end
         @(negedge clk);
         #1;
      end
      req_valid = 2'b00;
   endtask

   task automatic test_back_pressure;
      int n;
      @(negedge clk);
      rsp_ready = 2'b00;
      set_req(0, 64'd100, 64'd23, C_ADD);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      wait_rsp(n);
      // Requester 1 requests and asserts rsp_ready while requester 0 owns the response.
      set_req(1, 64'd1, 64'd1, C_ADD);
      rsp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (rsp_valid !== 2'b01 || rsp_result !== 64'd123 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL hold%0d: rv=%b res=%0d rr=%b expected 01 123 00",
                     i, rsp_valid, rsp_result, req_ready);
         end
      end
      req_valid = 2'b00;
      rsp_ready = 2'b01;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL hold_release: rsp_valid=%b expected 00", rsp_valid);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      int seen;
      rsp_ready = 2'b11;
      @(negedge clk);
      set_req(1, 64'd50, 64'd8, C_SUB);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      resetl = 1'b0;
      @(posedge clk);
      #1;
      resetl = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || alu_busa !== 64'd0 ||
          alu_busb !== 64'd0 || alu_ctrl !== 4'b0111 || rsp_result !== 64'd0 ||
          rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL midreset_state: rv=%b rr=%b a=%h b=%h c=%b res=%h z=%b e=%b",
                  rsp_valid, req_ready, alu_busa, alu_busb, alu_ctrl, rsp_result, rsp_zero, rsp_err);
      end
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid !== 2'b00) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL midreset_norsp: rsp_valid seen %0d times expected 0", seen);
      end
      set_req(0, 64'd1, 64'd1, C_ADD);
      set_req(1, 64'hF, 64'hF0, C_OR);
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL midreset_grant: req_ready=%b expected 01", req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      wait_rsp(n);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== 64'd2) begin
         errors++;
         $display("FAIL midreset_rsp: rv=%b res=%0d expected 01 2", rsp_valid, rsp_result);
      end
      @(negedge clk);
   endtask

   task automatic test_ctrl_check;
      int n;
      rsp_ready = 2'b01;
      @(negedge clk);
      set_req(0, 64'd3, 64'd4, 4'b1111);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      wait_rsp(n);
`ifdef ALU_CTRL_CHECK_EN
      checks++;
      if (n !== 2 || rsp_valid !== 2'b01 || rsp_result !== 64'd0 || rsp_zero !== 1'b1 ||
          rsp_err !== 1'b1 || alu_ctrl !== 4'b0111 || alu_busb !== 64'd0) begin
         errors++;
         $display("FAIL ctrl_illegal: n=%0d rv=%b res=%h z=%b e=%b c=%b b=%h expected 2 01 0 1 1 0111 0",
                  n, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_ctrl, alu_busb);
      end
`else
      checks++;
      if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || alu_ctrl !== 4'b1111) begin
         errors++;
         $display("FAIL ctrl_pass: rv=%b e=%b c=%b expected 01 0 1111", rsp_valid, rsp_err, alu_ctrl);
      end
`endif
      @(negedge clk);
   endtask

   initial begin
      resetl    = 1'b0;
      req_valid = 2'b00;
      req_a     = '0;
      req_b     = '0;
      req_ctrl  = '0;
      rsp_ready = 2'b00;
      test_reset();
      test_add();
      test_sub();
      test_round_robin();
      test_back_pressure();
      test_reset_mid();
      test_ctrl_check();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
